// File: rtl/rand_healthchk_if.sv
// Stream bundle for the health checker: 256-bit words in, 64-bit beats out.
// The master side feeds words and sinks beats; the slave side is the checker.
interface rand_healthchk_if;
  logic [255:0] rand_in;
  logic         rand_vld;
  logic         rand_take;
  logic [63:0]  out_data;
  logic         out_vld;
  logic         out_rdy;

  modport master (
    output rand_in, rand_vld, out_rdy,
    input  rand_take, out_data, out_vld
  );

  modport slave (
    input  rand_in, rand_vld, out_rdy,
    output rand_take, out_data, out_vld
  );
endinterface

// File: rtl/rand_healthchk.sv
// Online health tests (repetition + monobit balance) on 256-bit random words.
// Words that pass are forwarded as four 64-bit beats, MSB beat first.
module rand_healthchk #(
  parameter int WIN       = 64,
  parameter int BAL_TOL   = 512,
  parameter int REP_LIMIT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  rand_healthchk_if.slave bus,
  input  logic            clear_fail,
  output logic            health_ok,
  output logic            fail_rep,
  output logic            fail_bal,
  output logic            win_done
);
  typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_FAIL} state_t;

  localparam int               WIN_W    = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

  state_t           state_q, state_d;
  logic             buf_vld_q, buf_vld_d;
  logic [1:0]       beat_q, beat_d;
  logic [255:0]     word_q, word_d;
  logic [255:0]     prev_word_q, prev_word_d;
  logic             prev_vld_q, prev_vld_d;
  logic [3:0]       rep_cnt_q, rep_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [15:0]      ones_acc_q, ones_acc_d;
  logic             fail_rep_q, fail_rep_d;
  logic             fail_bal_q, fail_bal_d;
  logic             win_done_q, win_done_d;
  logic             health_ok_q, health_ok_d;

  logic               accept, take;
  logic               rep_match, rep_bad, bal_bad, win_last;
  logic [3:0]         rep_next;
  logic [8:0]         pop;
  logic [16:0]        total;
  logic signed [18:0] dev, dev_abs;
  logic [63:0]        beat_slice [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_beat
    assign beat_slice[gi] = word_q[255-64*gi -: 64];
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < 256; i++) begin
      pop = pop + 9'(bus.rand_in[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_vld_d   = buf_vld_q;
    beat_d      = beat_q;
    word_d      = word_q;
    prev_word_d = prev_word_q;
    prev_vld_d  = prev_vld_q;
    rep_cnt_d   = rep_cnt_q;
    win_cnt_d   = win_cnt_q;
    ones_acc_d  = ones_acc_q;
    fail_rep_d  = fail_rep_q;
    fail_bal_d  = fail_bal_q;
    win_done_d  = 1'b0;

    unique case (state_q)
      ST_WARMUP: accept = 1'b1;
      // Refill on the final beat's handshake so consecutive words flow without a bubble.
      ST_RUN:    accept = !buf_vld_q || (beat_q == 2'd3 && bus.out_rdy);
      default:   accept = 1'b0;
    endcase
    take = bus.rand_vld && accept;

    rep_match = prev_vld_q && (bus.rand_in == prev_word_q);
    rep_next  = rep_match ? rep_cnt_q + 4'd1 : 4'd0;
    rep_bad   = rep_match && (rep_next >= 4'(REP_LIMIT));

    win_last = (win_cnt_q == WIN_LAST);
    total    = {1'b0, ones_acc_q} + 17'(pop);
    dev      = $signed({2'b00, total}) - $signed(19'(WIN * 128));
    dev_abs  = dev[18] ? -dev : dev;
    bal_bad  = win_last && (dev_abs > $signed(19'(BAL_TOL)));

    if (buf_vld_q && bus.out_rdy) begin
      if (beat_q == 2'd3) begin
        buf_vld_d = 1'b0;
        beat_d    = 2'd0;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end

    if (take) begin
      prev_word_d = bus.rand_in;
      prev_vld_d  = 1'b1;
      rep_cnt_d   = rep_next;
      if (win_last) begin
        win_cnt_d  = '0;
        ones_acc_d = '0;
        win_done_d = 1'b1;
      end else begin
        win_cnt_d  = win_cnt_q + WIN_W'(1);
        ones_acc_d = total[15:0];
      end

      if (rep_bad || bal_bad) begin
        fail_rep_d = fail_rep_q | rep_bad;
        fail_bal_d = fail_bal_q | bal_bad;
        state_d    = ST_FAIL;
        buf_vld_d  = 1'b0;
        beat_d     = 2'd0;
      end else if (state_q == ST_RUN) begin
        word_d    = bus.rand_in;
        buf_vld_d = 1'b1;
        beat_d    = 2'd0;
      end else if (win_last) begin
        state_d = ST_RUN;
      end
    end

    if (state_q == ST_FAIL && clear_fail) begin
      state_d    = ST_WARMUP;
      fail_rep_d = 1'b0;
      fail_bal_d = 1'b0;
      rep_cnt_d  = '0;
      prev_vld_d = 1'b0;
      win_cnt_d  = '0;
      ones_acc_d = '0;
    end

    health_ok_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_WARMUP;
      buf_vld_q   <= 1'b0;
      beat_q      <= 2'd0;
      word_q      <= '0;
      prev_word_q <= '0;
      prev_vld_q  <= 1'b0;
      rep_cnt_q   <= '0;
      win_cnt_q   <= '0;
      ones_acc_q  <= '0;
      fail_rep_q  <= 1'b0;
      fail_bal_q  <= 1'b0;
      win_done_q  <= 1'b0;
      health_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_vld_q   <= buf_vld_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      prev_word_q <= prev_word_d;
      prev_vld_q  <= prev_vld_d;
      rep_cnt_q   <= rep_cnt_d;
      win_cnt_q   <= win_cnt_d;
      ones_acc_q  <= ones_acc_d;
      fail_rep_q  <= fail_rep_d;
      fail_bal_q  <= fail_bal_d;
      win_done_q  <= win_done_d;
      health_ok_q <= health_ok_d;
    end
  end

  assign bus.rand_take = take;
  assign bus.out_vld   = buf_vld_q;
  assign bus.out_data  = buf_vld_q ? beat_slice[beat_q] : 64'd0;
  assign health_ok     = health_ok_q;
  assign fail_rep      = fail_rep_q;
  assign fail_bal      = fail_bal_q;
  assign win_done      = win_done_q;
endmodule

// File: tb/tb_rand_healthchk.sv
// Directed bench for rand_healthchk: warmup, beat delivery, stall, health failures, reset.
module tb_rand_healthchk;
  logic clk;
  logic rstn;
  logic clear_fail;
  logic health_ok, fail_rep, fail_bal, win_done;

  rand_healthchk_if bus ();

  rand_healthchk #(.WIN(64), .BAL_TOL(512), .REP_LIMIT(1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .clear_fail (clear_fail),
    .health_ok  (health_ok),
    .fail_rep   (fail_rep),
    .fail_bal   (fail_bal),
    .win_done   (win_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] cnt_word(input logic [7:0] base);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[255-8*i -: 8] = base + 8'(i);
    return w;
  endfunction

  function automatic logic [255:0] ones_lo(input int n);
    logic [255:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = 1'b1;
    return w;
  endfunction

  task automatic beat_chk(input string tag, input logic [255:0] w, input int k);
    logic [255:0] sh;
    sh = w >> (64 * (3 - k));
    chk($sformatf("%s_vld%0d", tag, k), bus.out_vld, 1'b1);
    chk($sformatf("%s_beat%0d", tag, k), bus.out_data, sh[63:0]);
  endtask

  // One full balance window of alternating words starting from WARMUP.
  task automatic warm_window(input string tag, input logic [255:0] a, input logic [255:0] b,
                             input logic exp_fail);
    int takes, outs, oks, dones;
    takes = 0; outs = 0; oks = 0; dones = 0;
    bus.rand_vld = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.rand_in = (i % 2 == 0) ? a : b;
      #1;
      takes += int'(bus.rand_take);
      outs  += int'(bus.out_vld);
      oks   += int'(health_ok);
      dones += int'(win_done);
      tick();
    end
    bus.rand_vld = 1'b0;
    chk({tag, "_takes"}, takes, 64);
    chk({tag, "_no_out"}, outs, 0);
    chk({tag, "_no_ok_early"}, oks, 0);
    chk({tag, "_no_done_early"}, dones, 0);
    chk({tag, "_win_done"}, win_done, 1'b1);
    chk({tag, "_health_ok"}, health_ok, !exp_fail);
    chk({tag, "_fail_bal"}, fail_bal, exp_fail);
    chk({tag, "_fail_rep"}, fail_rep, 1'b0);
  endtask

  logic [255:0] w1, w2, w3, w4, p140, p136;
  int stall_takes;

  initial begin
    rstn = 1'b0; clear_fail = 1'b0;
    bus.rand_in = '0; bus.rand_vld = 1'b0; bus.out_rdy = 1'b0;
    w1 = cnt_word(8'h00); w2 = cnt_word(8'h20); w3 = cnt_word(8'h40); w4 = cnt_word(8'h60);
    p140 = ones_lo(140); p136 = ones_lo(136);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_health_ok", health_ok, 1'b0);
    chk("rst_out_vld", bus.out_vld, 1'b0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_rand_take", bus.rand_take, 1'b0);
    chk("rst_fail_rep", fail_rep, 1'b0);
    chk("rst_fail_bal", fail_bal, 1'b0);
    chk("rst_win_done", win_done, 1'b0);
    rstn = 1'b1;
    tick();

    warm_window("warm", {32{8'h55}}, {32{8'hAA}}, 1'b0);

    // Back-to-back words: W2 captured on W1's last beat.
    bus.out_rdy = 1'b1; bus.rand_vld = 1'b1; bus.rand_in = w1;
    #1;
    chk("w1_take", bus.rand_take, 1'b1);
    tick();
    bus.rand_in = w2;
    for (int k = 0; k < 4; k++) begin
      #1;
      beat_chk("w1", w1, k);
      chk($sformatf("w1_take_b%0d", k), bus.rand_take, k == 3);
      tick();
    end

    // Stall W2 on beat 1 for 10 cycles while W3 waits.
    bus.rand_in = w3;
    #1;
    beat_chk("w2", w2, 0);
    tick();
    bus.out_rdy = 1'b0;
    stall_takes = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      beat_chk($sformatf("w2_stall%0d", c), w2, 1);
      stall_takes += int'(bus.rand_take);
      tick();
    end
    chk("stall_no_take", stall_takes, 0);
    bus.out_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      beat_chk("w2", w2, k);
      chk($sformatf("w2_take_b%0d", k), bus.rand_take, k == 3);
      tick();
    end
    bus.rand_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      beat_chk("w3", w3, k);
      tick();
    end
    chk("w3_drained", bus.out_vld, 1'b0);

    // Repetition: W4 twice in a row.
    bus.rand_vld = 1'b1; bus.rand_in = w4;
    #1;
    chk("w4_take", bus.rand_take, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      beat_chk("w4", w4, k);
      chk($sformatf("w4_take_b%0d", k), bus.rand_take, k == 3);
      tick();
    end
    chk("rep_fail_rep", fail_rep, 1'b1);
    chk("rep_fail_bal", fail_bal, 1'b0);
    chk("rep_health_ok", health_ok, 1'b0);
    chk("rep_out_vld", bus.out_vld, 1'b0);
    chk("rep_no_take", bus.rand_take, 1'b0);
    tick();
    chk("rep_hold_no_take", bus.rand_take, 1'b0);
    bus.rand_vld = 1'b0;
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("clr_fail_rep", fail_rep, 1'b0);
    chk("clr_fail_bal", fail_bal, 1'b0);
    chk("clr_health_ok", health_ok, 1'b0);

    // Balance: 64 x 140 ones = 8960 fails; 64 x 136 = 8704 sits on the tolerance edge.
    warm_window("bal140", p140, p140 << 116, 1'b1);
    bus.rand_vld = 1'b1;
    #1;
    chk("bal140_no_take", bus.rand_take, 1'b0);
    bus.rand_vld = 1'b0;
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("clr2_fail_bal", fail_bal, 1'b0);
    warm_window("bal136", p136, p136 << 120, 1'b0);

    // Async reset while beat 2 is on the bus.
    bus.rand_vld = 1'b1; bus.rand_in = w1;
    tick();
    bus.rand_vld = 1'b0;
    tick();
    tick();
    beat_chk("rst_mid", w1, 2);
    rstn = 1'b0;
    #1;
    chk("arst_out_vld", bus.out_vld, 1'b0);
    chk("arst_out_data", bus.out_data, 64'd0);
    chk("arst_health_ok", health_ok, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    warm_window("post_rst", {32{8'h55}}, {32{8'hAA}}, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
